// File: rtl/id_ex_operand_stage.sv
// ID/EX register plus operand select: resolves EX/MEM and MEM/WB forwarding, feeds the ALU.
// Latency ID->EX one cycle; stalls decode on load-use or ex_ready=0, flush squashes EX.
module id_ex_operand_stage #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUSEL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [RADDR_W-1:0]  id_rs1_addr,
    input  logic [RADDR_W-1:0]  id_rs2_addr,
    input  logic                id_rs1_en,
    input  logic                id_rs2_en,
    input  logic [RADDR_W-1:0]  id_rd_addr,
    input  logic [ALUSEL_W-1:0] id_alu_sel,
    input  logic                id_op1_pc,
    input  logic                id_op2_imm,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                flush,
    input  logic                ex_ready,
    input  logic [RADDR_W-1:0]  mem_rd_addr,
    input  logic                mem_reg_write,
    input  logic [XLEN-1:0]     mem_result,
    input  logic [RADDR_W-1:0]  wb_rd_addr,
    input  logic                wb_reg_write,
    input  logic [XLEN-1:0]     wb_result,
    output logic                ex_valid,
    output logic [XLEN-1:0]     Alu_in1,
    output logic [XLEN-1:0]     Alu_in2,
    output logic [ALUSEL_W-1:0] ALUSel,
    output logic [XLEN-1:0]     ex_store_data,
    output logic [XLEN-1:0]     ex_pc,
    output logic [RADDR_W-1:0]  ex_rd_addr,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write
);

    logic                r_valid;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_rs1_data;
    logic [XLEN-1:0]     r_rs2_data;
    logic [XLEN-1:0]     r_imm;
    logic [RADDR_W-1:0]  r_rs1_addr;
    logic [RADDR_W-1:0]  r_rs2_addr;
    logic [RADDR_W-1:0]  r_rd_addr;
    logic [ALUSEL_W-1:0] r_alu_sel;
    logic                r_op1_pc;
    logic                r_op2_imm;
    logic                r_reg_write;
    logic                r_mem_read;
    logic                r_mem_write;

    logic                w_hazard;
    logic                w_adv;
    logic [XLEN-1:0]     w_id_rs1;
    logic [XLEN-1:0]     w_id_rs2;
    logic [XLEN-1:0]     w_fwd_rs1;
    logic [XLEN-1:0]     w_fwd_rs2;

    // A load in EX cannot forward its data yet, so a dependent decode must wait a cycle.
    assign w_hazard = r_valid & r_mem_read & (r_rd_addr != '0) &
                      ((id_rs1_en & (id_rs1_addr == r_rd_addr)) |
                       (id_rs2_en & (id_rs2_addr == r_rd_addr)));
    assign w_adv    = ~r_valid | ex_ready;
    assign id_ready = w_adv & ~w_hazard & ~flush;

    // Regfile is read-before-write, so a same-cycle write-back must be bypassed on capture.
    always_comb begin
        w_id_rs1 = id_rs1_data;
        w_id_rs2 = id_rs2_data;
        if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr))
            w_id_rs1 = wb_result;
        if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr))
            w_id_rs2 = wb_result;
    end

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        w_fwd_rs2 = r_rs2_data;
        if (mem_reg_write && (mem_rd_addr == r_rs1_addr) && (r_rs1_addr != '0))
            w_fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd_addr == r_rs1_addr) && (r_rs1_addr != '0))
            w_fwd_rs1 = wb_result;
        if (mem_reg_write && (mem_rd_addr == r_rs2_addr) && (r_rs2_addr != '0))
            w_fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd_addr == r_rs2_addr) && (r_rs2_addr != '0))
            w_fwd_rs2 = wb_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_alu_sel   <= '0;
            r_op1_pc    <= 1'b0;
            r_op2_imm   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_alu_sel   <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_adv) begin
            if (id_valid && !w_hazard) begin
                r_valid     <= 1'b1;
                r_pc        <= id_pc;
                r_rs1_data  <= w_id_rs1;
                r_rs2_data  <= w_id_rs2;
                r_imm       <= id_imm;
                r_rs1_addr  <= id_rs1_addr;
                r_rs2_addr  <= id_rs2_addr;
                r_rd_addr   <= id_rd_addr;
                r_alu_sel   <= id_alu_sel;
                r_op1_pc    <= id_op1_pc;
                r_op2_imm   <= id_op2_imm;
                r_reg_write <= id_reg_write;
                r_mem_read  <= id_mem_read;
                r_mem_write <= id_mem_write;
            end else begin
                r_valid     <= 1'b0;
                r_alu_sel   <= '0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end else begin
            // Latch forwarded operands while stalled; the producer may retire before we advance.
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end
    end

    assign ex_valid      = r_valid;
    assign Alu_in1       = r_op1_pc  ? r_pc  : w_fwd_rs1;
    assign Alu_in2       = r_op2_imm ? r_imm : w_fwd_rs2;
    assign ALUSel        = r_alu_sel;
    assign ex_store_data = w_fwd_rs2;
    assign ex_pc         = r_pc;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_reg_write  = r_valid & r_reg_write;
    assign ex_mem_read   = r_valid & r_mem_read;
    assign ex_mem_write  = r_valid & r_mem_write;

endmodule
